bcd_down_counter: RTL and testbench
===================================

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port load, input, 1 bit: load load_val into the count this cycle.
REQ-004 SHALL have port load_val, input, 8 bits: BCD value to load; [7:4] is tens, [3:0] is units.
REQ-005 SHALL have port en, input, 1 bit: count-down enable.
REQ-006 SHALL have port count, output, 8 bits: registered BCD count; [7:4] is tens, [3:0] is units.
REQ-007 SHALL have port busy, output, 1 bit: high while the state is RUN.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse on the cycle count becomes 8'h00 by decrement.

Function
REQ-009 SHALL implement states IDLE, RUN and DONE, held in a registered state variable.
REQ-010 SHALL give load priority over en in every state.
REQ-011 On load, SHALL clamp each load_val digit above 9 to 9 before storing it in count and in the reload register.
REQ-012 On load with a nonzero clamped value, SHALL enter RUN.
REQ-013 On load with a clamped value of 8'h00, SHALL enter IDLE with count=8'h00 and done=0.
REQ-014 In IDLE, SHALL hold count and ignore en.
REQ-015 In RUN with en=1, SHALL decrement count by one BCD step per cycle: units 0 becomes 9 with a borrow from tens; otherwise units decrements.
REQ-016 In RUN with en=0, SHALL hold count.
REQ-017 In RUN with en=1 and count=8'h01, SHALL register count=8'h00, assert done for exactly that next cycle, and enter DONE.
REQ-018 SHALL keep done a registered output that is never high on two consecutive cycles from a single terminal event.
REQ-019 SHALL never let count wrap below 8'h00 and never let it hold a non-BCD digit.
REQ-020 SHALL make busy=1 exactly when state is RUN; busy is 0 in the DONE cycle.
REQ-021 On simultaneous load and terminal decrement, SHALL let load win: done=0, new value loaded.

Reset
REQ-022 While rst=1 at a clock edge, SHALL set count=8'h00, state=IDLE, done=0, busy=0 and reload register=8'h00.
REQ-023 SHALL give rst priority over load and en, including mid-count in RUN.

Configuration
REQ-024 SHALL recognise the macro BCD_DOWN_COUNTER_AUTO_RELOAD_EN.
REQ-025 With BCD_DOWN_COUNTER_AUTO_RELOAD_EN defined, in DONE with en=1, SHALL reload count from the reload register and return to RUN on the next cycle.
REQ-026 Without BCD_DOWN_COUNTER_AUTO_RELOAD_EN, SHALL stay in DONE holding 8'h00, ignore en, and leave DONE only on load or rst.

Structure
REQ-027 SHALL take the following from a shared package:
- state encodings IDLE, RUN and DONE;
- digit width 4;
- constant DIGIT_MAX=9.
REQ-028 SHALL instantiate sub-module bcd_digit_dec twice (units and tens); bcd_digit_dec takes a 4-bit digit and a borrow-in, and outputs the decremented digit and a borrow-out.

Verification
REQ-029 SHALL cover: rst=1 for 1 cycle -> count=00, busy=0, done=0.
REQ-030 SHALL cover: load 8'h12, then en=1 for 12 cycles -> count sequence 12,11,10,09,...,01,00; done high only on the 00 cycle; busy falls with done.
REQ-031 SHALL cover: load 8'hAF -> count=8'h99, state RUN.
REQ-032 SHALL cover: in RUN at count=8'h05, assert rst -> count=00, state IDLE next cycle.
REQ-033 SHALL cover: at count=8'h01, assert load=1 with load_val=8'h30 and en=1 together -> count=8'h30, done=0.
REQ-034 SHALL cover: in DONE with en=1 -> with the macro, count=last load value and busy=1; without the macro, count stays 00 and busy stays 0.

Source files
------------

// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the two-digit BCD down counter: state encoding,
// digit width and the digit clamp helper.
package bcd_down_counter_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer: subtracts the borrow-in, wrapping 0 to 9
// and raising borrow-out when it wraps.
import bcd_down_counter_pkg::*;

module bcd_digit_dec (
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_borrow,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_borrow
);

    always_comb begin
        o_digit  = i_digit;
        o_borrow = 1'b0;
        if (i_borrow) begin
            if (i_digit == '0) begin
                o_digit  = DIGIT_MAX;
                o_borrow = 1'b1;
            end else begin
                o_digit = i_digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with IDLE/RUN/DONE control and a one-cycle done pulse.
// Optional BCD_DOWN_COUNTER_AUTO_RELOAD_EN: en in DONE reloads the last load value.
import bcd_down_counter_pkg::*;

module bcd_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic [7:0] count,
    output logic       busy,
    output logic       done
);

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    state_t      r_state;
    logic [7:0]  r_count;
    logic [7:0]  r_reload;
    logic        r_done;

    logic [7:0]         w_clamped;
    logic [DIGIT_W-1:0] w_units_dec;
    logic [DIGIT_W-1:0] w_tens_dec;
    logic               w_units_borrow;
    logic               w_tens_borrow;

    assign w_clamped = {clamp_digit(load_val[7:4]), clamp_digit(load_val[3:0])};

    bcd_digit_dec u_units (
        .i_digit  (r_count[3:0]),
        .i_borrow (1'b1),
        .o_digit  (w_units_dec),
        .o_borrow (w_units_borrow)
    );

    bcd_digit_dec u_tens (
        .i_digit  (r_count[7:4]),
        .i_borrow (w_units_borrow),
        .o_digit  (w_tens_dec),
        .o_borrow (w_tens_borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= 8'h00;
            r_reload <= 8'h00;
            r_done   <= 1'b0;
        end else if (load) begin
            r_count  <= w_clamped;
            r_reload <= w_clamped;
            r_done   <= 1'b0;
            r_state  <= (w_clamped == 8'h00) ? ST_IDLE : ST_RUN;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    // A tens borrow would mean wrapping below 00; never commit it
                    if (en && !w_tens_borrow) begin
                        r_count <= {w_tens_dec, w_units_dec};
                        if (r_count == 8'h01) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (AUTO_RELOAD && en) begin
                        r_count <= r_reload;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = (r_state == ST_RUN);
    assign done  = r_done;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: stimulus queues expected outputs,
// a monitor compares them against the DUT each cycle.
module tb_bcd_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic [7:0] count;
    logic       busy;
    logic       done;

    typedef struct {
        int         id;
        logic [7:0] c;
        logic       b;
        logic       d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    bcd_down_counter dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic l, input logic [7:0] v, input logic e,
                        input logic [7:0] ec, input logic eb, input logic ed);
        exp_t x;
        rst = r; load = l; load_val = v; en = e;
        @(posedge clk);
        x.id = step_id; x.c = ec; x.b = eb; x.d = ed;
        exp_q.push_back(x);
        step_id++;
        #1;
    endtask

    // Monitor: outputs are registered, so every cycle presents a result
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (count !== x.c || busy !== x.b || done !== x.d) begin
                errors++;
                $display("FAIL step%0d: count=%h busy=%b done=%b, expected count=%h busy=%b done=%b",
                         x.id, count, busy, done, x.c, x.b, x.d);
            end
        end
    end

    logic [7:0] dec_tab [12];

    initial begin
        dec_tab = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                    8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        rst = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0;
        @(posedge clk); #1;

        // reset
        step(1, 0, 8'h00, 0, 8'h00, 0, 0);
        // load 12 then count to zero
        step(0, 1, 8'h12, 0, 8'h12, 1, 0);
        for (int i = 0; i < 12; i++)
            step(0, 0, 8'h00, 1, dec_tab[i], (i != 11), (i == 11));
        // done pulse lasts one cycle
        step(0, 0, 8'h00, 0, 8'h00, 0, 0);
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        step(0, 0, 8'h00, 1, 8'h12, 1, 0);
`else
        step(0, 0, 8'h00, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 8'h00, 0, 0);
`endif
        // clamping and hold with en=0
        step(0, 1, 8'hAF, 0, 8'h99, 1, 0);
        step(0, 0, 8'h00, 1, 8'h98, 1, 0);
        step(0, 0, 8'h00, 0, 8'h98, 1, 0);
        // reset mid-count beats en and load
        step(0, 1, 8'h05, 0, 8'h05, 1, 0);
        step(1, 1, 8'h44, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 8'h00, 0, 0);
        // load beats terminal decrement
        step(0, 1, 8'h02, 1, 8'h02, 1, 0);
        step(0, 0, 8'h00, 1, 8'h01, 1, 0);
        step(0, 1, 8'h30, 1, 8'h30, 1, 0);
        step(0, 0, 8'h00, 1, 8'h29, 1, 0);
        // zero load goes idle; more clamp patterns
        step(0, 1, 8'h00, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 8'h00, 0, 0);
        step(0, 1, 8'h0F, 0, 8'h09, 1, 0);
        step(0, 1, 8'hC3, 0, 8'h93, 1, 0);
        step(0, 0, 8'h00, 1, 8'h92, 1, 0);
        // short run to done, then load out of DONE
        step(0, 1, 8'h01, 1, 8'h01, 1, 0);
        step(0, 0, 8'h00, 1, 8'h00, 0, 1);
        step(0, 1, 8'h20, 0, 8'h20, 1, 0);
        step(0, 0, 8'h00, 1, 8'h19, 1, 0);
        load = 1'b0; en = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
